// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the periodic pattern transmitter.
//   tx_state_t : states of the serial transmitter FSM
//   mode_t     : pattern generator mode select
//   lfsr_taps  : Fibonacci LFSR feedback mask for word widths 5..8
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_FIXED = 2'd3
  } mode_t;

  // Feedback mask for a shift-left Fibonacci LFSR: the new LSB is the XOR of
  // the state bits selected here. Bit k of the mask is the x^(k+1) term.
  //   5: x^5+x^3+1            6: x^6+x^5+1
  //   7: x^7+x^6+1            8: x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_taps(input int width);
    logic [7:0] taps;
    case (width)
      5:       taps = 8'h14;
      6:       taps = 8'h30;
      7:       taps = 8'h60;
      default: taps = 8'hB8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/uart_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// uart_pattern_tx_if
// Control and status bundle of the pattern transmitter.
//   en, mode, fixed_data          : controls, driven by the board top / bench
//   tx, tx_busy, sent, last_data,
//   overrun                       : line and status, driven by the transmitter
// The master modport belongs to whoever drives the controls; the
// transmitter itself uses the slave modport.
// ---------------------------------------------------------------------------
interface uart_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              en;
  logic [1:0]        mode;
  logic [DATA_W-1:0] fixed_data;
  logic              tx;
  logic              tx_busy;
  logic              sent;
  logic [DATA_W-1:0] last_data;
  logic              overrun;

  modport master (
    output en, mode, fixed_data,
    input  tx, tx_busy, sent, last_data, overrun
  );

  modport slave (
    input  en, mode, fixed_data,
    output tx, tx_busy, sent, last_data, overrun
  );
endinterface

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// 8N1-style serialiser: one start bit (0), DATA_W data bits LSB first, one
// stop bit (1), each CLKS_PER_BIT clocks long.
//   clk_50m : system clock
//   rst     : synchronous active-high reset, truncates any frame in flight
//   start   : launch request, only honoured while idle
//   data    : word to send, captured together with start
//   tx      : serial line, idles high (registered)
//   busy    : high for every cycle of a frame (registered)
//   done    : high during the final stop-bit cycle (registered)
// ---------------------------------------------------------------------------
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  tx_state_t         w_state_next;
  logic [TMR_W-1:0]  w_timer_next;
  logic [IDX_W-1:0]  w_bit_idx_next;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_bit_end;
  logic              w_tx_next;
  logic              w_busy_next;
  logic              w_done_next;

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_bit_end      = (r_timer == TMR_LAST);

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_START;
          w_timer_next = '0;
          w_shift_next = data;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_timer_next   = '0;
          w_bit_idx_next = '0;
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_timer_next = '0;
          w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
          if (r_bit_idx == IDX_LAST) begin
            w_state_next = ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase

    // Outputs are derived from the next state so that they can be registered
    // and still line up with the state they describe.
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
    w_done_next = (w_state_next == ST_STOP) && (w_timer_next == TMR_LAST);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: rtl/uart_pattern_tx.sv
// ---------------------------------------------------------------------------
// uart_pattern_tx
// Periodic test-pattern transmitter for UART bring-up. Every INTERVAL clocks
// (while enabled) it offers one word to its own serialiser; the word comes
// from an increment, decrement, LFSR or fixed pattern.
//   clk_50m : system clock
//   rst     : synchronous active-high reset
//   bus     : slave side of uart_pattern_tx_if
//             en         - run the interval counter (low holds it at 0)
//             mode       - 0 inc, 1 dec, 2 LFSR, 3 fixed
//             fixed_data - word used in fixed mode
//             tx         - serial line, idles high
//             tx_busy    - frame on the line
//             sent       - one-cycle pulse in the last stop-bit cycle
//             last_data  - most recently launched word
//             overrun    - sticky: a tick arrived while a frame was busy
// ---------------------------------------------------------------------------
module uart_pattern_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_W      = 8,
  parameter int INTERVAL    = 50_000_000
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  uart_pattern_tx_if.slave      bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W        = $clog2(INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);

  localparam logic [7:0]        TAPS_FULL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_pat;
  logic [DATA_W-1:0] r_last_data;
  logic              r_overrun;

  mode_t             w_mode;
  logic              w_tick;
  logic              w_busy;
  logic              w_launch;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_pat_next;
  logic              w_tx;
  logic              w_done;

  assign w_mode   = mode_t'(bus.mode);
  assign w_tick   = bus.en && (r_cnt == CNT_LAST);
  // The core's busy flag is registered from its next state, so it is high
  // exactly when the transmitter is outside IDLE, including the last stop
  // cycle. A tick in that cycle is therefore an overrun, not a launch.
  assign w_launch = w_tick && !w_busy;

  always_comb begin
    w_word = r_pat;
    case (w_mode)
      MODE_INC, MODE_DEC: w_word = r_pat;
      // An all-zero LFSR state would lock up; substitute 1.
      MODE_LFSR:          w_word = (r_pat == '0) ? DATA_W'(1) : r_pat;
      MODE_FIXED:         w_word = bus.fixed_data;
      default:            w_word = r_pat;
    endcase
  end

  always_comb begin
    w_pat_next = r_pat;
    case (w_mode)
      MODE_INC:   w_pat_next = w_word + DATA_W'(1);
      MODE_DEC:   w_pat_next = r_pat - DATA_W'(1);
      MODE_LFSR:  w_pat_next = {w_word[DATA_W-2:0], ^(w_word & TAPS)};
      MODE_FIXED: w_pat_next = r_pat;
      default:    w_pat_next = r_pat;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!bus.en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_pat       <= '0;
      r_last_data <= '0;
    end else if (w_launch) begin
      r_pat       <= w_pat_next;
      r_last_data <= w_word;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_tick && w_busy) begin
      r_overrun <= 1'b1;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_tx_core (
    .clk_50m (clk_50m),
    .rst     (rst),
    .start   (w_launch),
    .data    (w_word),
    .tx      (w_tx),
    .busy    (w_busy),
    .done    (w_done)
  );

  assign bus.tx        = w_tx;
  assign bus.tx_busy   = w_busy;
  assign bus.sent      = w_done;
  assign bus.last_data = r_last_data;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_pattern_tx
// Two instances: dut_a with INTERVAL=200 (normal pacing) and dut_b with
// INTERVAL=50 (overrun pacing). A frame-level model predicts every output on
// every cycle; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_pattern_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DW     = 8;
  localparam int INT_A  = 200;
  localparam int INT_B  = 50;
  localparam int FRAME  = (DW + 2) * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] fixed_a, fixed_b;

  uart_pattern_tx_if #(.DATA_W(DW)) bus_a ();
  uart_pattern_tx_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.en         = en_a;
  assign bus_a.mode       = mode_a;
  assign bus_a.fixed_data = fixed_a;
  assign bus_b.en         = en_b;
  assign bus_b.mode       = mode_b;
  assign bus_b.fixed_data = fixed_b;

  uart_pattern_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(DW), .INTERVAL(INT_A)) dut_a (
    .clk_50m (clk),
    .rst     (rst_a),
    .bus     (bus_a)
  );

  uart_pattern_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(DW), .INTERVAL(INT_B)) dut_b (
    .clk_50m (clk),
    .rst     (rst_b),
    .bus     (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit finished = 0;
  bit done_a   = 0;
  bit done_b   = 0;

  task automatic summary();
    if (!finished) begin
      finished = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      if (n_fail >= 40) summary();
    end
  endtask

  // ---------------- frame-level model ----------------
  // Word k of a frame: position p = cycles since launch; bit slot p/CPB is
  // start (0), data bits 1..DW (LSB first), stop (DW+1).
  function automatic logic [7:0] lfsr_model(input logic [7:0] s);
    // x^8 + x^6 + x^5 + x^4 + 1: feedback from stages 8, 6, 5, 4
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  int         m_cnt[2];
  int         m_rem[2];
  int         m_nl[2];
  logic [7:0] m_pat[2];
  logic [7:0] m_last[2];
  logic [7:0] m_word[2];
  bit         m_ovr[2];
  bit         m_valid[2];
  logic [7:0] m_q_a[$];
  logic [7:0] m_q_b[$];
  int         m_lc_b[$];
  int         cyc = 0;

  initial begin
    logic       r, e, tick, busy_now;
    logic [1:0] md;
    logic [7:0] fx, w;
    int         iv;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        r  = (i == 0) ? rst_a   : rst_b;
        e  = (i == 0) ? en_a    : en_b;
        md = (i == 0) ? mode_a  : mode_b;
        fx = (i == 0) ? fixed_a : fixed_b;
        iv = (i == 0) ? INT_A   : INT_B;
        if (r === 1'b1) begin
          m_cnt[i] = 0; m_rem[i] = 0; m_nl[i] = 0;
          m_pat[i] = 8'h00; m_last[i] = 8'h00; m_word[i] = 8'h00;
          m_ovr[i] = 0; m_valid[i] = 1;
          if (i == 0) m_q_a.delete(); else begin m_q_b.delete(); m_lc_b.delete(); end
        end else if (m_valid[i]) begin
          tick     = e && (m_cnt[i] == iv - 1);
          busy_now = (m_rem[i] > 0);
          if (m_rem[i] > 0) m_rem[i]--;
          if (tick) begin
            if (busy_now) begin
              m_ovr[i] = 1;
            end else begin
              case (md)
                2'd2:    w = (m_pat[i] == 8'h00) ? 8'h01 : m_pat[i];
                2'd3:    w = fx;
                default: w = m_pat[i];
              endcase
              m_last[i] = w; m_word[i] = w; m_rem[i] = FRAME; m_nl[i]++;
              if (i == 0) m_q_a.push_back(w);
              else begin m_q_b.push_back(w); m_lc_b.push_back(cyc); end
              case (md)
                2'd0:    m_pat[i] = w + 8'd1;
                2'd1:    m_pat[i] = m_pat[i] - 8'd1;
                2'd2:    m_pat[i] = lfsr_model(w);
                default: m_pat[i] = m_pat[i];
              endcase
            end
          end
          if (!e || m_cnt[i] == iv - 1) m_cnt[i] = 0;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_dut(input string tag, input int i, input logic a_tx, input logic a_busy,
                         input logic a_sent, input logic [7:0] a_last, input logic a_ovr);
    logic e_tx;
    int   pos, k;
    if (!m_valid[i]) return;
    pos = FRAME - m_rem[i];
    k   = pos / CPB;
    if (m_rem[i] == 0)  e_tx = 1'b1;
    else if (k == 0)    e_tx = 1'b0;
    else if (k <= DW)   e_tx = m_word[i][k-1];
    else                e_tx = 1'b1;
    chk({tag, ".tx"},        a_tx,   e_tx);
    chk({tag, ".tx_busy"},   a_busy, m_rem[i] > 0);
    chk({tag, ".sent"},      a_sent, m_rem[i] == 1);
    chk({tag, ".last_data"}, a_last, m_last[i]);
    chk({tag, ".overrun"},   a_ovr,  m_ovr[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_dut("a", 0, bus_a.tx, bus_a.tx_busy, bus_a.sent, bus_a.last_data, bus_a.overrun);
      cmp_dut("b", 1, bus_b.tx, bus_b.tx_busy, bus_b.sent, bus_b.last_data, bus_b.overrun);
    end
  end

  // ---------------- helpers for dut_a ----------------
  task automatic wait_launch_a(input int n, input int budget);
    int b;
    b = 0;
    while (m_nl[0] < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk("a.launch_wait", m_nl[0] >= n, 1);
  endtask

  task automatic reset_a();
    en_a  = 1'b0;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  // ---------------- dut_a scenarios ----------------
  initial begin
    logic [7:0] words[$];
    bit         seen[256];
    logic       prev;
    int         b, dups, zeros;

    rst_a = 1'b1; en_a = 1'b0; mode_a = 2'd0; fixed_a = 8'h00;
    repeat (3) @(negedge clk);
    chk("a.rst_tx",      bus_a.tx,        1);
    chk("a.rst_busy",    bus_a.tx_busy,   0);
    chk("a.rst_sent",    bus_a.sent,      0);
    chk("a.rst_last",    bus_a.last_data, 0);
    chk("a.rst_overrun", bus_a.overrun,   0);
    rst_a = 1'b0;

    // Increment mode: first launch INTERVAL cycles after en rises.
    @(negedge clk);
    mode_a = 2'd0; en_a = 1'b1;
    repeat (INT_A - 1) @(negedge clk);
    chk("a.first_idle_tx", bus_a.tx, 1);
    @(negedge clk);
    chk("a.first_fall_tx",   bus_a.tx,      0);
    chk("a.first_fall_busy", bus_a.tx_busy, 1);
    wait_launch_a(3, 3 * INT_A);
    repeat (FRAME + 5) @(negedge clk);
    chk("a.inc_w0", m_q_a[0], 8'h00);
    chk("a.inc_w1", m_q_a[1], 8'h01);
    chk("a.inc_w2", m_q_a[2], 8'h02);
    chk("a.inc_overrun", bus_a.overrun, 0);
    chk("a.inc_last", bus_a.last_data, 8'h02);

    // Increment wrap: one decrement launch leaves pat at 0xFF, then mode 0.
    reset_a();
    mode_a = 2'd1; en_a = 1'b1;
    wait_launch_a(1, 2 * INT_A);
    mode_a = 2'd0;
    wait_launch_a(3, 3 * INT_A);
    repeat (FRAME + 5) @(negedge clk);
    chk("a.wrap_w0", m_q_a[0], 8'h00);
    chk("a.wrap_w1", m_q_a[1], 8'hFF);
    chk("a.wrap_w2", m_q_a[2], 8'h00);

    // Decrement wrap from reset.
    reset_a();
    mode_a = 2'd1; en_a = 1'b1;
    wait_launch_a(3, 4 * INT_A);
    repeat (FRAME + 5) @(negedge clk);
    chk("a.dec_w0", m_q_a[0], 8'h00);
    chk("a.dec_w1", m_q_a[1], 8'hFF);
    chk("a.dec_w2", m_q_a[2], 8'hFE);
    chk("a.dec_last", bus_a.last_data, 8'hFE);

    // Reset in the middle of data bit 3 of frame 0x05.
    reset_a();
    mode_a = 2'd0; en_a = 1'b1;
    wait_launch_a(6, 7 * INT_A);
    chk("a.mid_word", m_q_a[5], 8'h05);
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
    chk("a.mid_busy", bus_a.tx_busy, 1);
    rst_a = 1'b1; en_a = 1'b0;
    @(negedge clk);
    chk("a.mid_rst_tx",   bus_a.tx,        1);
    chk("a.mid_rst_busy", bus_a.tx_busy,   0);
    chk("a.mid_rst_last", bus_a.last_data, 0);
    chk("a.mid_rst_sent", bus_a.sent,      0);
    rst_a = 1'b0; en_a = 1'b1;
    wait_launch_a(1, 2 * INT_A);
    chk("a.after_rst_word", m_q_a[0], 8'h00);
    chk("a.after_rst_last", bus_a.last_data, 8'h00);
    chk("a.after_rst_tx",   bus_a.tx, 0);

    // LFSR: 255 launches, all distinct and non-zero.
    reset_a();
    mode_a = 2'd2; en_a = 1'b1;
    prev = 1'b0; b = 0;
    while (words.size() < 255 && b < 256 * INT_A) begin
      @(negedge clk);
      b++;
      if (bus_a.tx_busy === 1'b1 && prev === 1'b0) words.push_back(bus_a.last_data);
      prev = bus_a.tx_busy;
    end
    chk("a.lfsr_count", words.size(), 255);
    chk("a.lfsr_w0", words[0], 8'h01);
    chk("a.lfsr_w1", words[1], 8'h02);
    chk("a.lfsr_model_w0", m_q_a[0], 8'h01);
    chk("a.lfsr_model_w1", m_q_a[1], 8'h02);
    dups = 0; zeros = 0;
    foreach (words[j]) begin
      if (words[j] == 8'h00) zeros++;
      if (seen[words[j]]) dups++;
      seen[words[j]] = 1'b1;
    end
    chk("a.lfsr_dups",  dups,  0);
    chk("a.lfsr_zeros", zeros, 0);
    en_a = 1'b0;
    done_a = 1;
  end

  // ---------------- dut_b: overrun pacing ----------------
  initial begin
    int b, n0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 2'd0; fixed_b = 8'hA5;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    en_b = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      case (k)
        49:  chk("b.pre_launch_tx", bus_b.tx, 1);
        50:  begin
               chk("b.launch0_tx",   bus_b.tx,        0);
               chk("b.launch0_last", bus_b.last_data, 8'h00);
             end
        99:  chk("b.ovr_before", bus_b.overrun, 0);
        100: chk("b.ovr_set",    bus_b.overrun, 1);
        149: begin
               chk("b.stop_sent", bus_b.sent,    1);
               chk("b.stop_busy", bus_b.tx_busy, 1);
             end
        150: begin
               chk("b.dropped_busy", bus_b.tx_busy, 0);
               chk("b.dropped_tx",   bus_b.tx,      1);
             end
        200: begin
               chk("b.launch1_tx",   bus_b.tx,        0);
               chk("b.launch1_last", bus_b.last_data, 8'h01);
             end
        default: ;
      endcase
    end
    chk("b.launch_count", m_q_b.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b.step_w%0d", i), m_q_b[i], i);
    chk("b.launch_spacing", m_lc_b[1] - m_lc_b[0], 150);
    chk("b.ovr_sticky", bus_b.overrun, 1);

    // Fixed mode takes effect at the next launch.
    mode_b = 2'd3;
    n0 = m_nl[1]; b = 0;
    while (m_nl[1] == n0 && b < 4 * INT_B) begin
      @(negedge clk);
      b++;
    end
    chk("b.fixed_wait", m_nl[1] > n0, 1);
    chk("b.fixed_last", bus_b.last_data, 8'hA5);
    en_b = 1'b0;
    done_b = 1;
  end

  initial begin
    wait (done_a && done_b);
    repeat (FRAME + 5) @(negedge clk);
    summary();
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, done_a=%0d done_b=%0d", done_a, done_b);
    summary();
  end

endmodule
